// File: rtl/ftsd_count_source_pkg.sv
// rtl/ftsd_count_source_pkg.sv - shared display types and constants for the count source and scan stage
//   state_t      : run/stop FSM state
//   bcd_t        : one BCD digit, BCD_MIN..BCD_MAX
//   SCAN_CODE0-3 : scan-select codes shared with the downstream scan multiplexer
package ftsd_count_source_pkg;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    localparam logic [1:0] SCAN_CODE0 = 2'b00;
    localparam logic [1:0] SCAN_CODE1 = 2'b01;
    localparam logic [1:0] SCAN_CODE2 = 2'b10;
    localparam logic [1:0] SCAN_CODE3 = 2'b11;

endpackage

// File: rtl/ftsd_count_source_bcd_digit.sv
// rtl/ftsd_count_source_bcd_digit.sv - single up/down BCD digit with step enable and clear
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : step this digit by one on this edge
//   i_dir      : 1 = up, 0 = down
//   i_clr      : synchronous clear to 0, beats i_en
//   o_digit    : registered digit value, always 0..9
//   o_carry    : combinational carry/borrow, high when this step rolls the digit over
module ftsd_count_source_bcd_digit
    import ftsd_count_source_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_dir,
    input  logic i_clr,
    output bcd_t o_digit,
    output logic o_carry
);

    bcd_t r_digit;

    // Carry out is the next digit's enable, so it must only fire on a real step.
    assign o_carry = i_en && !i_clr &&
                     (i_dir ? (r_digit >= BCD_MAX) : (r_digit == BCD_MIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= BCD_MIN;
        end else if (i_clr) begin
            r_digit <= BCD_MIN;
        end else if (i_en) begin
            if (i_dir) begin
                // >= keeps the digit inside 0..9 even from a corrupted value.
                r_digit <= (r_digit >= BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign o_digit = r_digit;

endmodule

// File: rtl/ftsd_count_source.sv
// rtl/ftsd_count_source.sv - scan-select generator and 4-digit BCD run/stop counter feeding the 14-segment scan stage
//   clk, rst_n   : system clock, asynchronous active-low reset
//   start_stop   : one-cycle pulse toggling STOP/RUN
//   clr          : synchronous clear of digits, divider and state
//   dir          : 1 = count up, 0 = count down, sampled on each tick
//   ftsd_ctl_en  : 2-bit scan select
//   dig0..dig3   : thousands..ones BCD digits
//   running      : high while in RUN
//   wrap         : one-cycle pulse on a 9999<->0000 roll
module ftsd_count_source
    import ftsd_count_source_pkg::*;
#(
    parameter int TICK_DIV = 40_000_000,
    parameter int SCAN_LSB = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       dir,
    output logic [1:0] ftsd_ctl_en,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       running,
    output logic       wrap
);

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = SCAN_LSB + 2;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DIV_W-1:0]  r_div;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_wrap;
    logic              w_tick;
    logic              w_step;
    logic [3:0]        w_en;
    logic [3:0]        w_carry;
    bcd_t              w_dig [0:3];

    // Free-running scan counter; deliberately unaffected by clr and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    assign ftsd_ctl_en = r_scan_cnt[SCAN_W-1:SCAN_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_STOP;
        end else if (start_stop) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    assign w_tick = (r_state == ST_RUN) && (r_div == DIV_LAST);
    assign w_step = w_tick && !clr;

    // Divider restarts from 0 whenever it is not counting a live RUN period,
    // so a pause discards the partial count and a resume gets a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (clr || start_stop || (r_state != ST_RUN) || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Index 3 is the ones digit; each carry enables the next more significant digit.
    assign w_en[3]   = w_step;
    assign w_en[2:0] = w_carry[3:1];

    for (genvar g = 0; g < 4; g++) begin : g_digit
        ftsd_count_source_bcd_digit u_digit (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en[g]),
            .i_dir   (dir),
            .i_clr   (clr),
            .o_digit (w_dig[g]),
            .o_carry (w_carry[g])
        );
    end

    // Carry out of the thousands digit is exactly the full-counter roll.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[0];
        end
    end

    assign dig0    = w_dig[0];
    assign dig1    = w_dig[1];
    assign dig2    = w_dig[2];
    assign dig3    = w_dig[3];
    assign running = (r_state == ST_RUN);
    assign wrap    = r_wrap;

endmodule
